encoder_msg_arbiter: RTL and testbench

- Merges the position-message AXI-Stream outputs of N_CH encoder monitors into one tagged AXI-Stream toward the host/DMA path.
- Round-robin, one message per grant, registered output.
- Per-channel enable mask: disabled channels are drained and discarded.
- Optional output-stall timeout with a saturating drop counter, so one stuck consumer cannot freeze the encoder monitors indefinitely.

---
 rtl/encoder_pkg.sv | 12 +
 rtl/encoder_msg_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 29 ++
 rtl/encoder_msg_arbiter.sv | 116 +++++++++++
 tb/tb_encoder_msg_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// Shared types and default sizes for the encoder message path.
package encoder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1
   } arb_state_t;

   localparam int ENC_DATA_W = 64;
   localparam int ENC_N_CH   = 4;

endpackage

// File: rtl/encoder_msg_arbiter_if.sv
// Stream bundle between the encoder monitors, the arbiter and the host path.
// The master modport is the arbiter side; slave is the surrounding fabric.
interface encoder_msg_arbiter_if
   import encoder_pkg::*;
#(
   parameter int  N_CH   = ENC_N_CH,
   parameter int  DATA_W = ENC_DATA_W,
   localparam int TID_W  = $clog2(N_CH)
) ();

   logic [N_CH*DATA_W-1:0] s_tdata;
   logic [N_CH-1:0]        s_tvalid;
   logic [N_CH-1:0]        s_tready;
   logic [DATA_W-1:0]      m_tdata;
   logic [TID_W-1:0]       m_tid;
   logic                   m_tvalid;
   logic                   m_tready;

   modport master (
      input  s_tdata, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tid, m_tvalid
   );

   modport slave (
      output s_tdata, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tid, m_tvalid
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping from N_CH-1 back to 0.
module rr_pick
   import encoder_pkg::*;
#(
   parameter int  N_CH  = ENC_N_CH,
   localparam int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_CH-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx   = '0;
      grant = '0;
      any   = |req;
      // Walk offsets from farthest to nearest so the nearest request wins.
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N_CH])
            idx = IDX_W'((int'(ptr) + k) % N_CH);
      end
      if (any)
         grant[idx] = 1'b1;
   end

endmodule

// File: rtl/encoder_msg_arbiter.sv
// Round-robin merge of N_CH encoder position streams into one tagged stream,
// with channel masking and an optional stall timeout that drops and counts.
module encoder_msg_arbiter
   import encoder_pkg::*;
#(
   parameter int N_CH    = ENC_N_CH,
   parameter int DATA_W  = ENC_DATA_W,
   parameter int TIMEOUT = 0,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           ch_enable,
   encoder_msg_arbiter_if.master     msg,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam int IDX_W = $clog2(N_CH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   arb_state_t        state_q, state_d;
   logic [N_CH-1:0]   req, grant;
   logic [IDX_W-1:0]  win_idx, rr_ptr;
   logic              any_req, take, timeout_hit, drop;
   logic [DATA_W-1:0] data_p1;
   logic [IDX_W-1:0]  tid_p1;
   logic              vld_p1;

   // Stage 0: request masking, grant and per-channel ready
   assign req = msg.s_tvalid & ch_enable;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (any_req)
   );

   // Disabled channels are always drained so their producers never stall.
   assign msg.s_tready = ~ch_enable | ((state_q == S_IDLE) ? grant : '0);

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               take    = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (msg.m_tready) begin
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               drop    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   generate
      if (TIMEOUT != 0) begin : g_wait
         localparam int WAIT_W = $clog2(TIMEOUT + 1);
         logic [WAIT_W-1:0] wait_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               wait_q <= '0;
            else if (take)
               wait_q <= '0;
            else if (state_q == S_SEND && !msg.m_tready)
               wait_q <= wait_q + 1'b1;
         end

         assign timeout_hit = (state_q == S_SEND) && !msg.m_tready &&
                              (wait_q == WAIT_W'(TIMEOUT - 1));
      end else begin : g_no_wait
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Stage 1: registered output, pointer and drop counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_ptr   <= '0;
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         tid_p1   <= '0;
         drop_cnt <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= (state_d == S_SEND);
         if (take) begin
            data_p1 <= msg.s_tdata[int'(win_idx) * DATA_W +: DATA_W];
            tid_p1  <= win_idx;
            rr_ptr  <= (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
         end
         if (drop)
            drop_cnt <= sat_inc(drop_cnt);
      end
   end

   assign msg.m_tdata  = data_p1;
   assign msg.m_tid    = tid_p1;
   assign msg.m_tvalid = vld_p1;

endmodule

// File: tb/tb_encoder_msg_arbiter.sv
// Directed bench for encoder_msg_arbiter: one instance without timeout, one with TIMEOUT=8.
module tb_encoder_msg_arbiter;
   import encoder_pkg::*;

   typedef struct packed {
      logic [1:0]  tid;
      logic [63:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  ch_en0, ch_en8;
   logic [15:0] dc0, dc8;
   int          checks;
   int          failures;
   exp_t        q0[$];
   exp_t        q8[$];

   encoder_msg_arbiter_if #(.N_CH(4), .DATA_W(64)) if0 ();
   encoder_msg_arbiter_if #(.N_CH(4), .DATA_W(64)) if8 ();

   encoder_msg_arbiter #(.N_CH(4), .DATA_W(64), .TIMEOUT(0), .CNT_W(16)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .ch_enable (ch_en0),
      .msg       (if0),
      .drop_cnt  (dc0)
   );

   encoder_msg_arbiter #(.N_CH(4), .DATA_W(64), .TIMEOUT(8), .CNT_W(16)) dut8 (
      .clk       (clk),
      .reset     (reset),
      .ch_enable (ch_en8),
      .msg       (if8),
      .drop_cnt  (dc8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set0(input int ch, input logic [63:0] v);
      if0.s_tdata[ch*64 +: 64] = v;
   endtask

   task automatic set8(input int ch, input logic [63:0] v);
      if8.s_tdata[ch*64 +: 64] = v;
   endtask

   // Settle, score any handshake about to complete, then advance one clock.
   task automatic cyc();
      exp_t e;
      #1;
      if (if0.m_tvalid && if0.m_tready) begin
         chk("sb0_nonempty", q0.size() != 0, 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("sb0_tid", if0.m_tid, e.tid);
            chk("sb0_data", if0.m_tdata, e.data);
         end
      end
      if (if8.m_tvalid && if8.m_tready) begin
         chk("sb8_nonempty", q8.size() != 0, 1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("sb8_tid", if8.m_tid, e.tid);
            chk("sb8_data", if8.m_tdata, e.data);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      ch_en0   = 4'hF;
      ch_en8   = 4'hF;
      if0.s_tdata  = '0;
      if0.s_tvalid = '0;
      if0.m_tready = 1'b0;
      if8.s_tdata  = '0;
      if8.s_tvalid = '0;
      if8.m_tready = 1'b0;
      @(negedge clk);
      @(negedge clk);

      chk("rst_vld", if0.m_tvalid, 0);
      chk("rst_data", if0.m_tdata, 0);
      chk("rst_tid", if0.m_tid, 0);
      chk("rst_drop", dc0, 0);
      reset = 1'b0;
      cyc();

      // Fairness: all channels valid, data = index
      for (int i = 0; i < 4; i++) set0(i, i);
      for (int i = 0; i < 6; i++) q0.push_back('{tid: 2'(i % 4), data: 64'(i % 4)});
      if0.m_tready = 1'b1;
      if0.s_tvalid = 4'b1111;
      for (int k = 1; k <= 11; k++) begin
         cyc();
         chk("fair_vld", if0.m_tvalid, k % 2);
      end
      if0.s_tvalid = 4'b0000;
      cyc();
      chk("fair_end_vld", if0.m_tvalid, 0);
      chk("fair_sb_empty", q0.size(), 0);

      // Single channel: ch2 carries 0x5
      set0(2, 64'h5);
      if0.s_tvalid = 4'b0100;
      q0.push_back('{tid: 2'd2, data: 64'h5});
      #1;
      chk("single_rdy", if0.s_tready, 4'b0100);
      cyc();
      chk("single_vld", if0.m_tvalid, 1);
      chk("single_data", if0.m_tdata, 64'h5);
      chk("single_tid", if0.m_tid, 2);
      if0.s_tvalid = 4'b0000;
      cyc();
      chk("single_vld_low", if0.m_tvalid, 0);

      // Pointer wrap: rr_ptr = 3, requests on ch0 and ch3
      set0(0, 64'hA0);
      set0(3, 64'hA3);
      if0.s_tvalid = 4'b1001;
      q0.push_back('{tid: 2'd3, data: 64'hA3});
      q0.push_back('{tid: 2'd0, data: 64'hA0});
      #1;
      chk("wrap_rdy_ch3", if0.s_tready, 4'b1000);
      cyc();
      chk("wrap_send_rdy", if0.s_tready, 4'b0000);
      if0.s_tvalid = 4'b0001;
      cyc();
      chk("wrap_rdy_ch0", if0.s_tready, 4'b0001);
      cyc();
      if0.s_tvalid = 4'b0000;
      cyc();
      chk("wrap_sb_empty", q0.size(), 0);

      // Back-pressure without timeout: ch1 message held for 10 cycles
      set0(1, 64'h77);
      if0.m_tready = 1'b0;
      if0.s_tvalid = 4'b0010;
      q0.push_back('{tid: 2'd1, data: 64'h77});
      cyc();
      if0.s_tvalid = 4'b1100;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("bp_vld", if0.m_tvalid, 1);
         chk("bp_data", if0.m_tdata, 64'h77);
         chk("bp_tid", if0.m_tid, 1);
         chk("bp_rdy", if0.s_tready, 4'b0000);
         chk("bp_drop", dc0, 0);
         cyc();
      end
      if0.s_tvalid = 4'b0000;
      if0.m_tready = 1'b1;
      cyc();
      chk("bp_done_vld", if0.m_tvalid, 0);
      chk("bp_sb_empty", q0.size(), 0);

      // Disabled channel is drained with no output
      ch_en0 = 4'b1101;
      if0.s_tvalid = 4'b0010;
      #1;
      chk("dis_rdy", if0.s_tready, 4'b0010);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("dis_no_out", if0.m_tvalid, 0);
      end
      if0.s_tvalid = 4'b0000;
      ch_en0 = 4'hF;
      cyc();

      // Reset mid-transfer, then next grant starts from ch0
      set0(0, 64'h99);
      if0.m_tready = 1'b0;
      if0.s_tvalid = 4'b0001;
      cyc();
      chk("rst_mid_vld_before", if0.m_tvalid, 1);
      if0.s_tvalid = 4'b0000;
      reset = 1'b1;
      #1;
      chk("rst_mid_vld", if0.m_tvalid, 0);
      chk("rst_mid_data", if0.m_tdata, 0);
      chk("rst_mid_drop", dc0, 0);
      cyc();
      reset = 1'b0;
      cyc();
      set0(0, 64'hB0);
      set0(1, 64'hB1);
      if0.m_tready = 1'b1;
      if0.s_tvalid = 4'b0011;
      q0.push_back('{tid: 2'd0, data: 64'hB0});
      q0.push_back('{tid: 2'd1, data: 64'hB1});
      #1;
      chk("post_rst_rdy", if0.s_tready, 4'b0001);
      cyc();
      if0.s_tvalid = 4'b0010;
      cyc();
      cyc();
      if0.s_tvalid = 4'b0000;
      cyc();
      chk("post_rst_sb_empty", q0.size(), 0);

      // Timeout = 8: stall until dropped
      set8(2, 64'hC2);
      if8.m_tready = 1'b0;
      if8.s_tvalid = 4'b0100;
      cyc();
      if8.s_tvalid = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk("to_vld_held", if8.m_tvalid, 1);
         chk("to_drop_pending", dc8, 0);
         cyc();
      end
      chk("to_vld_dropped", if8.m_tvalid, 0);
      chk("to_drop_cnt", dc8, 1);
      cyc();

      // Timeout = 8 with m_tready rising in the final cycle
      set8(3, 64'hC3);
      if8.s_tvalid = 4'b1000;
      q8.push_back('{tid: 2'd3, data: 64'hC3});
      cyc();
      if8.s_tvalid = 4'b0000;
      for (int k = 1; k <= 7; k++) begin
         #1;
         chk("to2_vld_held", if8.m_tvalid, 1);
         cyc();
      end
      if8.m_tready = 1'b1;
      #1;
      chk("to2_vld_last", if8.m_tvalid, 1);
      cyc();
      chk("to2_vld_done", if8.m_tvalid, 0);
      chk("to2_drop_cnt", dc8, 1);
      chk("to2_sb_empty", q8.size(), 0);
      chk("dut0_drop_final", dc0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
